// File: rtl/msrv32_pkg.sv
// Shared load-unit definitions: funct3 codes, FSM encoding, timeout default.
package msrv32_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lu_state_e;

  // funct3 values that do not name a load
  function automatic logic is_reserved(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // halfword loads need an even address, word loads a multiple of four
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LHU)) mis = off[0];
    else if (funct3 == FUNCT3_LW)                         mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module msrv32_load_align
  import msrv32_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [2:0]  funct3_in,
  input  logic [1:0]  off_in,
  output logic [31:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lane select followed by extension according to load type
  always_comb begin
    byte_sel = 8'h00;
    half_sel = off_in[1] ? data_in[31:16] : data_in[15:0];
    result_c = data_in;
    case (off_in)
      2'd0:    byte_sel = data_in[7:0];
      2'd1:    byte_sel = data_in[15:8];
      2'd2:    byte_sel = data_in[23:16];
      default: byte_sel = data_in[31:24];
    endcase
    case (funct3_in)
      FUNCT3_LB:  result_c = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: result_c = {24'h000000, byte_sel};
      FUNCT3_LH:  result_c = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LHU: result_c = {16'h0000, half_sel};
      default:    result_c = data_in;
    endcase
  end

endmodule

// File: rtl/msrv32_load_unit_ctrl.sv
// Load unit: issues word-aligned reads with req/ack, aligns the result,
// and flags misaligned loads, reserved funct3 and memory timeouts.
module msrv32_load_unit_ctrl
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        ld_req_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic        flush_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_dmrd_ack_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmrd_req_out,
  output logic [31:0] lu_output_out,
  output logic        lu_valid_out,
  output logic        lu_busy_out,
  output logic        lu_misaligned_out,
  output logic        lu_fault_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lu_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      out_q, out_d;
  logic             req_q, req_d;
  logic             valid_d, mis_d, fault_d;
  logic [31:0]      aligned_c;

  msrv32_load_align u_align (
    .data_in   (ms_riscv32_mp_dmdata_in),
    .funct3_in (f3_q),
    .off_in    (off_q),
    .result_c  (aligned_c)
  );

  // state and output registers
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      f3_q              <= 3'b000;
      off_q             <= 2'b00;
      addr_q            <= 32'h0;
      out_q             <= 32'h0;
      req_q             <= 1'b0;
      lu_valid_out      <= 1'b0;
      lu_busy_out       <= 1'b0;
      lu_misaligned_out <= 1'b0;
      lu_fault_out      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      f3_q              <= f3_d;
      off_q             <= off_d;
      addr_q            <= addr_d;
      out_q             <= out_d;
      req_q             <= req_d;
      lu_valid_out      <= valid_d;
      lu_busy_out       <= (state_d != ST_IDLE);
      lu_misaligned_out <= mis_d;
      lu_fault_out      <= fault_d;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    out_d   = out_q;
    req_d   = req_q;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (ld_req_in && !flush_in) begin
          if (is_reserved(funct3_in)) begin
            fault_d = 1'b1;
          end else if (is_misaligned(funct3_in, iadder_in[1:0])) begin
            mis_d = 1'b1;
          end else begin
            f3_d    = funct3_in;
            off_d   = iadder_in[1:0];
            addr_d  = {iadder_in[31:2], 2'b00};
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush_in) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (ms_riscv32_mp_dmrd_ack_in) begin
          out_d   = aligned_c;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ms_riscv32_mp_dmaddr_out   = addr_q;
  assign ms_riscv32_mp_dmrd_req_out = req_q;
  assign lu_output_out              = out_q;

endmodule

// File: tb/tb_msrv32_load_unit_ctrl.sv
// Scoreboard bench for the load unit: driver pushes expected pulses, monitor pops on each pulse.
module tb_msrv32_load_unit_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        ld_req;
  logic [2:0]  funct3;
  logic [31:0] iadder;
  logic        flush;
  logic [31:0] dmdata;
  logic        ack;
  logic [31:0] dmaddr;
  logic        req;
  logic [31:0] lu_out;
  logic        lu_valid;
  logic        lu_busy;
  logic        lu_mis;
  logic        lu_fault;

  typedef struct {
    int          kind;   // 0 valid, 1 misaligned, 2 fault
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  msrv32_load_unit_ctrl dut (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_n_in     (rst_n),
    .ld_req_in                  (ld_req),
    .funct3_in                  (funct3),
    .iadder_in                  (iadder),
    .flush_in                   (flush),
    .ms_riscv32_mp_dmdata_in    (dmdata),
    .ms_riscv32_mp_dmrd_ack_in  (ack),
    .ms_riscv32_mp_dmaddr_out   (dmaddr),
    .ms_riscv32_mp_dmrd_req_out (req),
    .lu_output_out              (lu_out),
    .lu_valid_out               (lu_valid),
    .lu_busy_out                (lu_busy),
    .lu_misaligned_out          (lu_mis),
    .lu_fault_out               (lu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req_v, $time);
    end
  endtask

  // reference load result from the architectural rules
  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] d, input int off);
    logic [31:0] v;
    if (f3 == 0 || f3 == 4) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (f3 == 0 && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // monitor: any result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (lu_valid || lu_mis || lu_fault)) begin
      exp_t e;
      int   k;
      k = lu_valid ? 0 : (lu_mis ? 1 : 2);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got kind %0d expected none at %0t", k, $time);
      end else begin
        e = exp_q.pop_front();
        if (k != e.kind || (lu_valid + lu_mis + lu_fault) != 1) begin
          n_err++;
          $display("FAIL pulse_kind: got v%0b m%0b f%0b expected kind %0d at %0t",
                   lu_valid, lu_mis, lu_fault, e.kind, $time);
        end else if (k == 0 && lu_out !== e.data) begin
          n_err++;
          $display("FAIL load_data: got 0x%08h expected 0x%08h at %0t", lu_out, e.data, $time);
        end
      end
    end
  end

  // one load; ack_at/flush_at are WAIT-cycle indices (large = never)
  task automatic run_load(input int f3, input logic [31:0] addr, input logic [31:0] data,
                          input int ack_at, input int flush_at);
    int   size;
    bit   rsv;
    bit   mis;
    int   end_i;
    int   req_cnt;
    exp_t e;
    rsv  = (f3 == 3 || f3 == 6 || f3 == 7);
    size = (f3 == 1 || f3 == 5) ? 2 : ((f3 == 2) ? 4 : 1);
    mis  = !rsv && ((addr % size) != 0);
    @(posedge clk); #1;
    ld_req = 1'b1; funct3 = 3'(f3); iadder = addr;
    @(posedge clk); #1;
    ld_req = 1'b0;
    if (rsv || mis) begin
      e.kind = rsv ? 2 : 1; e.data = 32'h0;
      exp_q.push_back(e);
      check("reject_req", {31'h0, req}, 32'h0);
      check("reject_busy", {31'h0, lu_busy}, 32'h0);
      @(posedge clk); #1;
      check("reject_req_later", {31'h0, req}, 32'h0);
    end else begin
      end_i = min3(ack_at, flush_at, TMO - 1);
      if (flush_at <= end_i) begin
        // flushed: nothing reported
      end else if (ack_at <= end_i) begin
        e.kind = 0; e.data = ref_load(f3, data, int'(addr % 4)); exp_q.push_back(e);
      end else begin
        e.kind = 2; e.data = 32'h0; exp_q.push_back(e);
      end
      check("dmaddr", dmaddr, addr & 32'hFFFFFFFC);
      check("busy_wait", {31'h0, lu_busy}, 32'h1);
      req_cnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (!req) break;
        req_cnt++;
        if (i == ack_at) begin ack = 1'b1; dmdata = data; end
        else dmdata = $urandom;
        if (i == flush_at) flush = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; flush = 1'b0;
      end
      check("req_cycles", 32'(req_cnt), 32'(end_i + 1));
      if (flush_at <= end_i && ack_at > flush_at && ack_at < 40) begin
        // late ack after abort must be dropped
        ack = 1'b1; dmdata = data;
        @(posedge clk); #1;
        ack = 1'b0;
      end
      @(posedge clk); #1;
      check("idle_busy", {31'h0, lu_busy}, 32'h0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ld_req = 1'b0; funct3 = 3'b000; iadder = 32'h0;
    flush = 1'b0; dmdata = 32'h0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_busy", {31'h0, lu_busy}, 32'h0);
    check("rst_out", lu_out, 32'h0);
    check("rst_addr", dmaddr, 32'h0);
    rst_n = 1'b1;

    // directed cases
    run_load(2, 32'h100, 32'hDEADBEEF, 3, 99);
    check("hold_out", lu_out, 32'hDEADBEEF);
    run_load(0, 32'h203, 32'h80112233, 0, 99);
    run_load(4, 32'h203, 32'h80112233, 1, 99);
    run_load(5, 32'h202, 32'h80112233, 2, 99);
    run_load(1, 32'h101, 32'h0, 0, 99);
    run_load(2, 32'h102, 32'h0, 0, 99);
    run_load(3, 32'h100, 32'h0, 0, 99);
    run_load(2, 32'h300, 32'h12345678, 99, 99);
    run_load(2, 32'h304, 32'h12345678, 2, 1);
    run_load(2, 32'h308, 32'h12345678, 1, 1);
    run_load(2, 32'h30C, 32'hCAFEF00D, 15, 99);

    // flush together with request in IDLE: nothing happens
    @(posedge clk); #1;
    ld_req = 1'b1; flush = 1'b1; funct3 = 3'b010; iadder = 32'h400;
    @(posedge clk); #1;
    ld_req = 1'b0; flush = 1'b0;
    check("flush_idle_req", {31'h0, req}, 32'h0);

    // reset mid-WAIT
    @(posedge clk); #1;
    ld_req = 1'b1; funct3 = 3'b010; iadder = 32'h500;
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'h0, req}, 32'h0);
    check("midrst_busy", {31'h0, lu_busy}, 32'h0);
    check("midrst_out", lu_out, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_load(2, 32'h600, 32'h0BADF00D, 1, 99);

    // random loads
    for (int n = 0; n < 80; n++) begin
      int          f3, a_at, f_at;
      logic [31:0] addr;
      f3   = int'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (f3 == 1 || f3 == 5) addr[0] = 1'b0;
        if (f3 == 2) addr[1:0] = 2'b00;
      end
      a_at = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 6));
      f_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : 99;
      run_load(f3, addr, $urandom, a_at, f_at);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
